// File: rtl/regfile_write_arbiter_pkg.sv
// Shared requester ids, sizes and helpers for the register-file write arbiter.
package regfile_write_arbiter_pkg;

   localparam int unsigned REQ_PIPE    = 0;
   localparam int unsigned REQ_MULTDIV = 1;
   localparam int unsigned REQ_EXC     = 2;
   localparam int unsigned NUM_REQ     = 3;
   localparam int unsigned NUM_REGS    = 32;
   localparam int unsigned REQ_IDW     = 2;

   typedef logic [NUM_REQ-1:0] req_vec_t;
   typedef logic [REQ_IDW-1:0] req_id_t;

   function automatic req_id_t req_encode(input req_vec_t vec);
      req_id_t id;
      id = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (vec[i]) id = REQ_IDW'(i);
      end
      return id;
   endfunction

endpackage

// File: rtl/regwr_onehot_decode.sv
// Register address to one-hot select decoder, purely combinational.
module regwr_onehot_decode
   import regfile_write_arbiter_pkg::*;
#(
   parameter int unsigned AddrW = 5
) (
   input  logic [AddrW-1:0]    addr_i,
   output logic [NUM_REGS-1:0] onehot_o
);

   always_comb begin
      onehot_o         = '0;
      onehot_o[addr_i] = 1'b1;
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates three writeback sources onto the single register-file write port and tracks
// destinations awaiting writeback for hazard stalls.
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned REG_AW       = 5,
   parameter int unsigned DATA_W       = 32
) (
   input  logic                      clock,
   input  logic                      ctrl_reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*REG_AW-1:0] req_reg,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      reserve_en,
   input  logic [REG_AW-1:0]         reserve_reg,
   output logic                      ctrl_writeEnable,
   output logic [REG_AW-1:0]         ctrl_writeReg,
   output logic [DATA_W-1:0]         data_writeReg,
   output logic [NUM_REGS-1:0]       write_onehot,
   output logic [REQ_IDW-1:0]        grant_id,
   output logic [NUM_REGS-1:0]       pending_mask
);

   localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

   logic                 we_q, we_d;
   logic [REG_AW-1:0]    wreg_q, wreg_d;
   logic [DATA_W-1:0]    wdata_q, wdata_d;
   req_id_t              gid_q, gid_d;
   // 0: multdiv preferred on the next req1/req2 tie, 1: exception source preferred.
   logic                 rr_q, rr_d;
   logic [CntW-1:0]      cnt1_q, cnt1_d;
   logic [CntW-1:0]      cnt2_q, cnt2_d;
   logic [NUM_REGS-1:0]  pending_q, pending_d;

   req_vec_t             grant;
   logic                 starved1, starved2;
   logic                 accept;
   req_id_t              sel_id;
   logic [REG_AW-1:0]    sel_reg;
   logic [DATA_W-1:0]    sel_data;
   logic [NUM_REGS-1:0]  dec_onehot;

   // Arbitration: a starved secondary source outranks the pipeline.
   always_comb begin
      grant    = '0;
      starved1 = req_valid[REQ_MULTDIV] && (cnt1_q == CntMax);
      starved2 = req_valid[REQ_EXC] && (cnt2_q == CntMax);
      if (ctrl_reset) begin
         grant = '0;
      end else if (starved1 && starved2) begin
         grant[rr_q ? REQ_EXC : REQ_MULTDIV] = 1'b1;
      end else if (starved1) begin
         grant[REQ_MULTDIV] = 1'b1;
      end else if (starved2) begin
         grant[REQ_EXC] = 1'b1;
      end else if (req_valid[REQ_PIPE]) begin
         grant[REQ_PIPE] = 1'b1;
      end else if (req_valid[REQ_MULTDIV] && req_valid[REQ_EXC]) begin
         grant[rr_q ? REQ_EXC : REQ_MULTDIV] = 1'b1;
      end else if (req_valid[REQ_MULTDIV]) begin
         grant[REQ_MULTDIV] = 1'b1;
      end else if (req_valid[REQ_EXC]) begin
         grant[REQ_EXC] = 1'b1;
      end
   end

   assign req_ready = grant;
   assign accept    = |grant;
   assign sel_id    = req_encode(grant);
   assign sel_reg   = req_reg[sel_id*REG_AW +: REG_AW];
   assign sel_data  = req_data[sel_id*DATA_W +: DATA_W];

   always_comb begin
      we_d    = accept && (sel_reg != '0);
      wreg_d  = wreg_q;
      wdata_d = wdata_q;
      gid_d   = gid_q;
      rr_d    = rr_q;
      if (accept) begin
         wreg_d  = sel_reg;
         wdata_d = sel_data;
         gid_d   = sel_id;
      end
      if (grant[REQ_MULTDIV]) rr_d = 1'b1;
      if (grant[REQ_EXC])     rr_d = 1'b0;
   end

   // Starvation counters saturate and clear on grant or when the source goes idle.
   always_comb begin
      cnt1_d = '0;
      cnt2_d = '0;
      if (req_valid[REQ_MULTDIV] && !grant[REQ_MULTDIV]) begin
         cnt1_d = (cnt1_q == CntMax) ? CntMax : cnt1_q + CntW'(1);
      end
      if (req_valid[REQ_EXC] && !grant[REQ_EXC]) begin
         cnt2_d = (cnt2_q == CntMax) ? CntMax : cnt2_q + CntW'(1);
      end
   end

   // Set is applied after clear so a same-edge reserve of the written register wins.
   always_comb begin
      pending_d = pending_q;
      if (accept) pending_d[sel_reg] = 1'b0;
      if (reserve_en && (reserve_reg != '0)) pending_d[reserve_reg] = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         we_q      <= 1'b0;
         wreg_q    <= '0;
         wdata_q   <= '0;
         gid_q     <= '0;
         rr_q      <= 1'b0;
         cnt1_q    <= '0;
         cnt2_q    <= '0;
         pending_q <= '0;
      end else begin
         we_q      <= we_d;
         wreg_q    <= wreg_d;
         wdata_q   <= wdata_d;
         gid_q     <= gid_d;
         rr_q      <= rr_d;
         cnt1_q    <= cnt1_d;
         cnt2_q    <= cnt2_d;
         pending_q <= pending_d;
      end
   end

   regwr_onehot_decode #(
      .AddrW (REG_AW)
   ) u_onehot_decode (
      .addr_i   (wreg_q),
      .onehot_o (dec_onehot)
   );

   assign ctrl_writeEnable = we_q;
   assign ctrl_writeReg    = wreg_q;
   assign data_writeReg    = wdata_q;
   assign grant_id         = gid_q;
   assign pending_mask     = pending_q;
   assign write_onehot     = we_q ? dec_onehot : '0;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a scoreboard queue of expected writes.
module tb_regfile_write_arbiter;

   localparam int unsigned RegAw = 5;
   localparam int unsigned DataW = 32;

   logic        clock;
   logic        ctrl_reset;
   logic [2:0]  req_valid;
   logic [14:0] req_reg;
   logic [95:0] req_data;
   logic [2:0]  req_ready;
   logic        reserve_en;
   logic [4:0]  reserve_reg;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic [31:0] write_onehot;
   logic [1:0]  grant_id;
   logic [31:0] pending_mask;

   typedef struct packed {
      logic        we;
      logic [4:0]  rg;
      logic [31:0] data;
      logic [1:0]  gid;
      logic        chk_rd;
   } exp_t;

   exp_t        sbq[$];
   logic [4:0]  m_reg;
   logic [31:0] m_data;
   logic [1:0]  m_gid;
   int          total;
   int          bad;

   regfile_write_arbiter dut (
      .clock            (clock),
      .ctrl_reset       (ctrl_reset),
      .req_valid        (req_valid),
      .req_reg          (req_reg),
      .req_data         (req_data),
      .req_ready        (req_ready),
      .reserve_en       (reserve_en),
      .reserve_reg      (reserve_reg),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .data_writeReg    (data_writeReg),
      .write_onehot     (write_onehot),
      .grant_id         (grant_id),
      .pending_mask     (pending_mask)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int id, input logic [4:0] rg, input logic [31:0] d);
      req_reg[id*RegAw +: RegAw]  = rg;
      req_data[id*DataW +: DataW] = d;
   endtask

   // One clock: check the combinational grant, queue the expected write, check it next edge.
   task automatic cyc(input string tag, input int id);
      exp_t       e;
      logic [2:0] rdy;
      #1;
      rdy      = '0;
      e.we     = 1'b0;
      e.chk_rd = 1'b1;
      if (id >= 0) begin
         rdy[id]  = 1'b1;
         m_reg    = req_reg[id*RegAw +: RegAw];
         m_data   = req_data[id*DataW +: DataW];
         m_gid    = 2'(id);
         e.we     = (m_reg != 5'd0);
         e.chk_rd = (m_reg != 5'd0);
      end
      e.rg   = m_reg;
      e.data = m_data;
      e.gid  = m_gid;
      chk({tag, "/ready"}, 32'(req_ready), 32'(rdy));
      sbq.push_back(e);
      @(posedge clock);
      #1;
      e = sbq.pop_front();
      chk({tag, "/we"}, 32'(ctrl_writeEnable), 32'(e.we));
      chk({tag, "/gid"}, 32'(grant_id), 32'(e.gid));
      chk({tag, "/onehot"}, write_onehot, e.we ? (32'd1 << e.rg) : 32'd0);
      if (e.chk_rd) begin
         chk({tag, "/reg"}, 32'(ctrl_writeReg), 32'(e.rg));
         chk({tag, "/data"}, data_writeReg, e.data);
      end
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      ctrl_reset  = 1'b1;
      req_valid   = '0;
      req_reg     = '0;
      req_data    = '0;
      reserve_en  = 1'b0;
      reserve_reg = '0;
      m_reg       = '0;
      m_data      = '0;
      m_gid       = '0;
      #2;
      chk("rst/we", 32'(ctrl_writeEnable), 32'd0);
      chk("rst/onehot", write_onehot, 32'd0);
      chk("rst/gid", 32'(grant_id), 32'd0);
      chk("rst/mask", pending_mask, 32'd0);
      chk("rst/ready", 32'(req_ready), 32'd0);
      @(negedge clock);
      ctrl_reset = 1'b0;

      // Lone multdiv write plus a reservation of r12.
      set_req(1, 5'd5, 32'hDEADBEEF);
      req_valid   = 3'b010;
      reserve_en  = 1'b1;
      reserve_reg = 5'd12;
      cyc("t2", 1);
      reserve_en = 1'b0;
      req_valid  = '0;
      chk("t2/mask", pending_mask, 32'h0000_1000);

      // Async reset while the write is on the port.
      req_valid  = 3'b111;
      ctrl_reset = 1'b1;
      #1;
      chk("t1/we", 32'(ctrl_writeEnable), 32'd0);
      chk("t1/onehot", write_onehot, 32'd0);
      chk("t1/gid", 32'(grant_id), 32'd0);
      chk("t1/reg", 32'(ctrl_writeReg), 32'd0);
      chk("t1/data", data_writeReg, 32'd0);
      chk("t1/mask", pending_mask, 32'd0);
      chk("t1/ready", 32'(req_ready), 32'd0);
      @(negedge clock);
      ctrl_reset = 1'b0;
      req_valid  = '0;
      m_reg      = '0;
      m_data     = '0;
      m_gid      = '0;

      // req1/req2 round robin starting with req1.
      set_req(1, 5'd10, 32'hA000_0010);
      set_req(2, 5'd11, 32'hB000_0011);
      req_valid = 3'b110;
      cyc("t4a", 1);
      cyc("t4b", 2);
      cyc("t4c", 1);
      cyc("t4d", 2);
      req_valid = '0;
      cyc("idle4", -1);

      // req0 dominates until req1 starves.
      set_req(0, 5'd3, 32'h0000_00A0);
      set_req(1, 5'd7, 32'h0000_00B1);
      req_valid = 3'b011;
      repeat (4) cyc("t3_req0", 0);
      cyc("t3_starve", 1);
      set_req(1, 5'd8, 32'h0000_00B2);
      cyc("t3_resume", 0);
      req_valid = '0;
      cyc("idle3", -1);

      // Scoreboard set/clear/collision.
      reserve_en  = 1'b1;
      reserve_reg = 5'd9;
      cyc("t5_res", -1);
      chk("t5/mask_set", pending_mask, 32'h0000_0200);
      reserve_en = 1'b0;
      set_req(1, 5'd9, 32'h0000_00C9);
      req_valid = 3'b010;
      cyc("t5_w9", 1);
      chk("t5/mask_clr", pending_mask, 32'd0);
      req_valid  = '0;
      reserve_en = 1'b1;
      cyc("t5_res2", -1);
      chk("t5/mask_set2", pending_mask, 32'h0000_0200);
      set_req(1, 5'd9, 32'h0000_00CA);
      req_valid = 3'b010;
      cyc("t5_both", 1);
      chk("t5/mask_setwins", pending_mask, 32'h0000_0200);
      req_valid   = '0;
      reserve_reg = 5'd0;
      cyc("t5_r0", -1);
      chk("t5/mask_r0", pending_mask, 32'h0000_0200);
      reserve_en = 1'b0;

      // Write to r0: handshake completes, no regfile write.
      set_req(0, 5'd0, 32'h0000_1234);
      req_valid = 3'b001;
      cyc("t6", 0);
      req_valid = '0;
      chk("t6/mask", pending_mask, 32'h0000_0200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
